// File: rtl/mp_pkg.sv
// Shared constants, step codes and segment helpers for the 514-bit carry-save accumulator.
package mp_pkg;

  localparam int unsigned WIDTH     = 514;
  localparam int unsigned SEG_W     = 128;
  localparam int unsigned NSEG      = 4;
  // The top segment absorbs the two bits left over above 4*128.
  localparam int unsigned SEG_TOP_W = WIDTH - (NSEG - 1) * SEG_W;

  typedef enum logic [3:0] {
    STEP_SEG0 = 4'd0,
    STEP_SEG1 = 4'd1,
    STEP_SEG2 = 4'd2,
    STEP_SEG3 = 4'd3,
    STEP_CLR  = 4'd4,
    STEP_IDLE = 4'd8
  } step_e;

  // Lowest bit index of segment k.
  function automatic int unsigned seg_lo(input logic [1:0] k);
    return SEG_W * k;
  endfunction

  // Highest bit index of segment k.
  function automatic int unsigned seg_hi(input logic [1:0] k);
    return (k == 2'(NSEG - 1)) ? WIDTH - 1 : seg_lo(k) + SEG_W - 1;
  endfunction

  // Right-aligned mask covering exactly the bits of segment k.
  function automatic logic [SEG_TOP_W-1:0] seg_mask(input logic [1:0] k);
    return SEG_TOP_W'({1'b0, {SEG_TOP_W{1'b1}}} >> (SEG_TOP_W - (seg_hi(k) - seg_lo(k) + 1)));
  endfunction

endpackage

// File: rtl/mp_adder_csa_row.sv
// Parameterised 3:2 compressor: bitwise sum and majority vectors, no carry propagation.
module csa_row #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] maj
);

  assign sum = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/mp_adder.sv
// 514-bit carry-save accumulator with segmented resolution into a binary result.
// Optional macro MPADDER_TRUE_RESULT_EN adds a full-width trueResult = S + C output.
module mp_adder
  import mp_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_a,
  input  logic             subtract,
  input  logic             shift,
  input  logic             enableC,
  input  logic [3:0]       showFluffyPonies,
  output logic [WIDTH-1:0] debugResult,
  output logic             cZero
`ifdef MPADDER_TRUE_RESULT_EN
  ,
  output logic [WIDTH-1:0] trueResult
`endif
);

  logic [WIDTH-1:0] s_q, s_d, c_q, c_d;
  logic             sc_q, sc_d;

  logic [WIDTH-1:0] t, sum0, maj0, cn;
  logic [WIDTH-1:0] sum1, maj1;
  logic             k_bit;

  // Main layer: fold the (possibly inverted) operand into the redundant state.
  assign t = in_a ^ {WIDTH{subtract}};

  csa_row #(.W(WIDTH)) u_csa_main (
    .a  (s_q),
    .b  (c_q),
    .c  (t),
    .sum(sum0),
    .maj(maj0)
  );

  // Two's-complement +1 for subtraction rides in the free carry LSB.
  assign cn    = {maj0[WIDTH-2:0], subtract};
  assign k_bit = sum0[0] & cn[0];

  // Halving layer: the two dropped LSBs only matter if both are set, and then add one.
  csa_row #(.W(WIDTH)) u_csa_shift (
    .a  ({1'b0, sum0[WIDTH-1:1]}),
    .b  ({1'b0, cn[WIDTH-1:1]}),
    .c  (WIDTH'(k_bit)),
    .sum(sum1),
    .maj(maj1)
  );

  // Shared segment adder; the step code selects which segment is fed through it.
  logic [1:0]           seg_k;
  logic [WIDTH-1:0]     seg_field;
  logic [SEG_TOP_W-1:0] seg_a, seg_b;
  logic [SEG_TOP_W:0]   seg_sum;

  assign seg_k     = showFluffyPonies[1:0];
  assign seg_field = WIDTH'(seg_mask(seg_k)) << seg_lo(seg_k);
  assign seg_a     = SEG_TOP_W'(s_q >> seg_lo(seg_k)) & seg_mask(seg_k);
  assign seg_b     = SEG_TOP_W'(c_q >> seg_lo(seg_k)) & seg_mask(seg_k);
  assign seg_sum   = {1'b0, seg_a} + {1'b0, seg_b} + (SEG_TOP_W + 1)'(sc_q);

  // Next state: accumulate wins over any step code; otherwise run a resolution step.
  always_comb begin
    s_d  = s_q;
    c_d  = c_q;
    sc_d = sc_q;
    if (enableC) begin
      sc_d = 1'b0;
      if (shift) begin
        s_d = sum1;
        c_d = {maj1[WIDTH-2:0], 1'b0};
      end else begin
        s_d = sum0;
        c_d = cn;
      end
    end else if (showFluffyPonies <= 4'(STEP_SEG3)) begin
      s_d  = (s_q & ~seg_field)
           | ((WIDTH'(seg_sum[SEG_TOP_W-1:0]) << seg_lo(seg_k)) & seg_field);
      c_d  = c_q & ~seg_field;
      // Top-segment overflow wraps modulo 2^514 and is discarded.
      sc_d = (seg_k == 2'(NSEG - 1)) ? 1'b0 : seg_sum[SEG_W];
    end else if (showFluffyPonies == 4'(STEP_CLR)) begin
      sc_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_q  <= '0;
      c_q  <= '0;
      sc_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      c_q  <= c_d;
      sc_q <= sc_d;
    end
  end

  assign debugResult = s_q;
  assign cZero       = (c_q == '0) && !sc_q;

`ifdef MPADDER_TRUE_RESULT_EN
  assign trueResult = s_q + c_q;
`endif

  // Bits discarded by construction (modulo-2^514 carries).
  logic unused_bits;
  assign unused_bits = ^{maj0[WIDTH-1], maj1[WIDTH-1], seg_sum[SEG_TOP_W]};

endmodule

// File: tb/tb_mp_adder.sv
// Scoreboard bench for mp_adder: stimulus pushes expected results, a negedge monitor checks them.
module tb_mp_adder;

  localparam int W = 514;

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] in_a;
  logic         subtract, shift, enableC;
  logic [3:0]   showFluffyPonies;
  logic [W-1:0] debugResult;
  logic         cZero;
`ifdef MPADDER_TRUE_RESULT_EN
  logic [W-1:0] trueResult;
`endif

  always #5 clk = ~clk;

  mp_adder dut (
    .clk             (clk),
    .resetn          (resetn),
    .in_a            (in_a),
    .subtract        (subtract),
    .shift           (shift),
    .enableC         (enableC),
    .showFluffyPonies(showFluffyPonies),
    .debugResult     (debugResult),
    .cZero           (cZero)
`ifdef MPADDER_TRUE_RESULT_EN
    ,
    .trueResult      (trueResult)
`endif
  );

  typedef struct {
    string        name;
    logic [W-1:0] val;
    logic         cz;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] model;

  // Monitor: compare every queued expectation against the DUT outputs.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (debugResult !== e.val || cZero !== e.cz) begin
        errors++;
        $display("FAIL %s: got debugResult=%0h cZero=%b, required %0h / %b",
                 e.name, debugResult, cZero, e.val, e.cz);
      end
`ifdef MPADDER_TRUE_RESULT_EN
      if (e.cz) begin
        checks++;
        if (trueResult !== e.val) begin
          errors++;
          $display("FAIL %s_true: got trueResult=%0h, required %0h", e.name, trueResult, e.val);
        end
      end
`endif
    end
  end

  function automatic logic [W-1:0] rnd514();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic expect_now(input string name, input logic [W-1:0] v, input logic cz);
    exp_t e;
    e.name = name;
    e.val  = v;
    e.cz   = cz;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model  = '0;
  endtask

  // One accumulate cycle; the model applies the operation arithmetically.
  task automatic acc(input logic [W-1:0] v, input bit sub, input bit sh,
                     input logic [3:0] code = 4'd8);
    logic [W-1:0] nv;
    in_a             = v;
    subtract         = sub;
    shift            = sh;
    enableC          = 1'b1;
    showFluffyPonies = code;
    @(posedge clk);
    #1;
    enableC          = 1'b0;
    shift            = 1'b0;
    subtract         = 1'b0;
    showFluffyPonies = 4'd8;
    nv    = sub ? model - v : model + v;
    model = sh ? nv >> 1 : nv;
  endtask

  task automatic step(input logic [3:0] code);
    showFluffyPonies = code;
    @(posedge clk);
    #1;
    showFluffyPonies = 4'd8;
  endtask

  // Steps 0..3, optionally with hold codes between them, optionally followed by code 4.
  task automatic resolve(input bit gaps, input bit clr);
    for (int k = 0; k < 4; k++) begin
      step(4'(k));
      if (gaps) begin
        int n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) step(4'($urandom_range(5, 15)));
      end
    end
    if (clr) step(4'd4);
  endtask

  initial begin
    logic [W-1:0] n_const;
    logic [W-1:0] v;
    resetn           = 1'b0;
    in_a             = '0;
    subtract         = 1'b0;
    shift            = 1'b0;
    enableC          = 1'b0;
    showFluffyPonies = 4'd8;
    model            = '0;

    // Reset state and idle hold
    repeat (2) @(posedge clk);
    #1;
    expect_now("reset_held", '0, 1'b1);
    resetn = 1'b1;
    repeat (3) step(4'd8);
    expect_now("reset_idle", '0, 1'b1);

    // Add and resolve: S is the plain XOR before resolution, carries pending
    acc(514'd5, 0, 0);
    acc(514'd7, 0, 0);
    expect_now("pre_resolve", 514'd2, 1'b0);
    resolve(0, 1);
    expect_now("add_5_7", 514'd12, 1'b1);

    // Montgomery-style sequence
    do_reset();
    n_const        = rnd514();
    n_const[513:511] = 3'b001;
    n_const[0]     = 1'b1;
    acc(514'd3, 0, 0);
    acc(514'd3, 0, 0);
    acc(514'd0, 0, 0);
    repeat (3) acc(n_const, 0, 0);
    acc(514'd1, 0, 1);
    resolve(0, 1);
    step(4'd8);
    expect_now("montgomery", (514'd7 + 514'd3 * n_const) >> 1, 1'b1);

    // Subtraction
    do_reset();
    acc(514'd10, 0, 0);
    acc(514'd3, 1, 0);
    resolve(0, 1);
    expect_now("sub_10_3", 514'd7, 1'b1);
    do_reset();
    acc(514'd1, 1, 0);
    resolve(0, 0);
    expect_now("sub_to_all_ones", {W{1'b1}}, 1'b1);

    // Odd shift truncates; top-bit carry-out is dropped
    do_reset();
    acc(514'd5, 0, 1);
    resolve(0, 1);
    expect_now("odd_shift", 514'd2, 1'b1);
    do_reset();
    v = '0;
    v[513] = 1'b1;
    acc(v, 0, 0);
    acc(v, 0, 0);
    resolve(0, 1);
    expect_now("top_wrap", '0, 1'b1);

    // Accumulate has priority over a step code
    do_reset();
    v = rnd514();
    acc(v, 0, 0, 4'd0);
    expect_now("prio_acc", v, 1'b1);

    // Segment carry pending after step 0; code 4 clears it
    do_reset();
    acc({386'd0, {128{1'b1}}}, 0, 0);
    acc(514'd1, 0, 0);
    step(4'd0);
    expect_now("sc_pending", '0, 1'b0);
    step(4'd4);
    expect_now("clr_step", '0, 1'b1);

    // Accumulate mid-resolve clears the pending segment carry
    do_reset();
    acc({386'd0, {128{1'b1}}}, 0, 0);
    acc(514'd1, 0, 0);
    step(4'd0);
    acc(514'd0, 0, 0, 4'd1);
    expect_now("acc_clears_sc", '0, 1'b1);

    // Reset asserted between steps 1 and 2 clears state without a clock edge
    do_reset();
    acc(rnd514(), 0, 0);
    acc(rnd514(), 0, 0);
    step(4'd0);
    step(4'd1);
    #1;
    resetn = 1'b0;
    #1;
    expect_now("reset_mid_resolve", '0, 1'b1);
    resetn = 1'b1;
    model  = '0;

    // Random full-width add/subtract rounds, continuing from the resolved value
    for (int r = 0; r < 20; r++) begin
      int nops = $urandom_range(1, 6);
      for (int i = 0; i < nops; i++) acc(rnd514(), 1'($urandom_range(0, 1)), 0);
      resolve(1, 1'($urandom_range(0, 1)));
      expect_now($sformatf("rand_addsub_%0d", r), model, 1'b1);
    end

    // Random shifted rounds with operands small enough that no value reaches 2^514
    for (int r = 0; r < 10; r++) begin
      int nops = $urandom_range(1, 5);
      do_reset();
      for (int i = 0; i < nops; i++) acc(rnd514() >> 20, 0, 1'($urandom_range(0, 1)));
      resolve(1, 1);
      expect_now($sformatf("rand_shift_%0d", r), model, 1'b1);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
